// File: rtl/tl_phase_ctrl.sv
// Traffic-light phase controller: drives the phase timer, sequences highway/farm lights,
// and drops into a flashing-yellow fault mode when an expected expiry never arrives.
// Optional all-red clearance between yellow and the opposite green: define TL_ALLRED_EN.
module tl_phase_ctrl #(
   parameter int unsigned WDOG_CYC   = 300_000_000,
   parameter int unsigned FLASH_CYC  = 25_000_000,
   parameter int unsigned ALLRED_CYC = 49_999_999
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       car,
   input  logic       long_to,
   input  logic       short_to,
   output logic       timer_start,
   output logic       timer_sel,
   output logic [1:0] hwy_light,
   output logic [1:0] farm_light,
   output logic       fault,
   output logic [2:0] state_o
);

   localparam int WDOG_W  = $clog2(WDOG_CYC + 1);
   localparam int FLASH_W = $clog2(FLASH_CYC + 1);
   localparam logic [WDOG_W-1:0]  WDOG_MAX   = WDOG_W'(WDOG_CYC);
   localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_CYC - 1);
`ifdef TL_ALLRED_EN
   localparam int AR_W = $clog2(ALLRED_CYC + 1);
   localparam logic [AR_W-1:0] AR_LAST = AR_W'(ALLRED_CYC);
`endif

   localparam logic [1:0] LT_RED = 2'b00;
   localparam logic [1:0] LT_YEL = 2'b01;
   localparam logic [1:0] LT_GRN = 2'b10;
   localparam logic [1:0] LT_OFF = 2'b11;

   typedef enum logic [2:0] {
      S_HG    = 3'd0,
      S_HY    = 3'd1,
      S_FG    = 3'd2,
      S_FY    = 3'd3,
      S_FAULT = 3'd4
`ifdef TL_ALLRED_EN
      , S_AR1 = 3'd5
      , S_AR2 = 3'd6
`endif
   } state_t;

   state_t               state_q, state_d;
   logic                 sel_q, sel_d;
   logic                 start_q, start_d;
   logic                 car_meta_q, car_sync_q;
   logic                 car_req_q, car_req_d;
   logic [WDOG_W-1:0]    wdog_q, wdog_d;
   logic [FLASH_W-1:0]   flash_cnt_q, flash_cnt_d;
   logic                 flash_yel_q, flash_yel_d;
   logic                 accept;
   logic                 in_ar;
   logic                 wdog_hit;
`ifdef TL_ALLRED_EN
   logic [AR_W-1:0]      ar_cnt_q, ar_cnt_d;
   assign in_ar = (state_q == S_AR1) || (state_q == S_AR2);
`else
   assign in_ar = 1'b0;
`endif

   // Only the expiry of the interval actually running counts.
   assign accept   = sel_q ? short_to : long_to;
   assign wdog_hit = (state_q != S_FAULT) && !in_ar && (wdog_q == WDOG_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_HG;
         sel_q       <= 1'b0;
         start_q     <= 1'b1;
         car_meta_q  <= 1'b0;
         car_sync_q  <= 1'b0;
         car_req_q   <= 1'b0;
         wdog_q      <= '0;
         flash_cnt_q <= '0;
         flash_yel_q <= 1'b1;
`ifdef TL_ALLRED_EN
         ar_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         start_q     <= start_d;
         car_meta_q  <= car;
         car_sync_q  <= car_meta_q;
         car_req_q   <= car_req_d;
         wdog_q      <= wdog_d;
         flash_cnt_q <= flash_cnt_d;
         flash_yel_q <= flash_yel_d;
`ifdef TL_ALLRED_EN
         ar_cnt_q    <= ar_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      start_d     = 1'b0;
      car_req_d   = car_req_q;
      wdog_d      = wdog_q;
      flash_cnt_d = '0;
      flash_yel_d = 1'b1;
`ifdef TL_ALLRED_EN
      ar_cnt_d    = '0;
`endif

      if (start_q)
         wdog_d = '0;
      else if ((state_q != S_FAULT) && !in_ar && (wdog_q != WDOG_MAX))
         wdog_d = wdog_q + WDOG_W'(1);

      if (((state_q == S_HG) || (state_q == S_HY)) && car_sync_q)
         car_req_d = 1'b1;

      if (wdog_hit) begin
         state_d = S_FAULT;
      end else begin
         case (state_q)
            S_HG: if (accept) begin
               state_d = car_req_q ? S_HY : S_HG;
               sel_d   = car_req_q;
               start_d = 1'b1;
            end
            S_HY: if (accept) begin
`ifdef TL_ALLRED_EN
               state_d = S_AR1;
`else
               state_d = S_FG;
               sel_d   = 1'b0;
               start_d = 1'b1;
`endif
            end
            S_FG: if (accept) begin
               state_d = S_FY;
               sel_d   = 1'b1;
               start_d = 1'b1;
            end
            S_FY: if (accept) begin
`ifdef TL_ALLRED_EN
               state_d = S_AR2;
`else
               state_d = S_HG;
               sel_d   = 1'b0;
               start_d = 1'b1;
`endif
            end
            S_FAULT: begin
               if (flash_cnt_q == FLASH_LAST) begin
                  flash_cnt_d = '0;
                  flash_yel_d = !flash_yel_q;
               end else begin
                  flash_cnt_d = flash_cnt_q + FLASH_W'(1);
                  flash_yel_d = flash_yel_q;
               end
            end
`ifdef TL_ALLRED_EN
            S_AR1, S_AR2: begin
               if (ar_cnt_q == AR_LAST) begin
                  state_d = (state_q == S_AR1) ? S_FG : S_HG;
                  sel_d   = 1'b0;
                  start_d = 1'b1;
               end else begin
                  ar_cnt_d = ar_cnt_q + AR_W'(1);
               end
            end
`endif
            default: state_d = S_FAULT;
         endcase
      end

      // A request is served by exactly one farm green.
      if ((state_d == S_FG) && (state_q != S_FG))
         car_req_d = 1'b0;
   end

   always_comb begin
      hwy_light  = LT_RED;
      farm_light = LT_RED;
      case (state_q)
         S_HG:    hwy_light  = LT_GRN;
         S_HY:    hwy_light  = LT_YEL;
         S_FG:    farm_light = LT_GRN;
         S_FY:    farm_light = LT_YEL;
         S_FAULT: begin
            hwy_light  = flash_yel_q ? LT_YEL : LT_OFF;
            farm_light = flash_yel_q ? LT_YEL : LT_OFF;
         end
         default: ;
      endcase
   end

   assign timer_start = start_q;
   assign timer_sel   = sel_q;
   assign fault       = (state_q == S_FAULT);
   assign state_o     = state_q;

endmodule
